// File: rtl/fft_sdf_stage.sv
// rtl/fft_sdf_stage.sv - radix-2 single-path delay-feedback DIF butterfly stage
// One complex sample per accepted cycle; the SPAN-deep delay line pairs x[k] with x[k+SPAN].
module fft_sdf_stage #(
    parameter int DW = 16,
    parameter int TW = 16,
    parameter int SPAN = 32,
    parameter int SCALE = 1,
    localparam int LOG2SPAN = $clog2(SPAN)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic [2*DW-1:0]     in_data,
    input  logic                flush,
    input  logic                inverse,
    output logic [LOG2SPAN-1:0] tw_idx,
    input  logic [2*TW-1:0]     tw,
    output logic                out_valid,
    output logic [2*DW-1:0]     out_data,
    output logic                out_sof
);

    localparam int PW = DW + TW + 2;
    localparam logic signed [PW-1:0] CM_MAX = {{(PW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [PW-1:0] CM_MIN = {{(PW-DW+1){1'b1}}, {(DW-1){1'b0}}};
    localparam logic signed [PW-1:0] CM_RND = {{(PW-TW+2){1'b0}}, 1'b1, {(TW-3){1'b0}}};

    logic [LOG2SPAN:0]   cnt;
    logic                phase;
    logic [LOG2SPAN-1:0] k;
    logic                accept;
    logic [2*DW-1:0]     s;
    logic [2*DW-1:0]     a;
    logic [2*DW-1:0]     mem [SPAN];
    logic                diff_vld;
    logic                inv_q;

    logic [DW-1:0]        sum_re, sum_im;
    logic signed [DW-1:0] dr, di;
    logic signed [TW-1:0] wr;
    logic signed [TW:0]   wi;
    logic signed [PW-1:0] pr, pi;
    logic [2*DW-1:0]      cm;

    // DW+1-bit sum/difference brought back to DW bits: halve (floor) or saturate
    function automatic logic [DW-1:0] fit(input logic [DW:0] v);
        if (SCALE != 0)
            return v[DW:1];
        else if (v[DW] != v[DW-1])
            return v[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
        else
            return v[DW-1:0];
    endfunction

    function automatic logic [DW-1:0] sat_cm(input logic signed [PW-1:0] v);
        logic signed [PW-1:0] sh;
        sh = v >>> (TW - 2);
        if (sh > CM_MAX)
            return CM_MAX[DW-1:0];
        else if (sh < CM_MIN)
            return CM_MIN[DW-1:0];
        else
            return sh[DW-1:0];
    endfunction

    assign phase  = cnt[LOG2SPAN];
    assign k      = cnt[LOG2SPAN-1:0];
    assign tw_idx = k;
    assign accept = in_valid | flush;
    assign s      = in_valid ? in_data : '0;
    assign a      = mem[k];

    always_comb begin
        sum_re = fit({a[2*DW-1], a[2*DW-1:DW]} + {s[2*DW-1], s[2*DW-1:DW]});
        sum_im = fit({a[DW-1], a[DW-1:0]} + {s[DW-1], s[DW-1:0]});
        dr = $signed(fit({a[2*DW-1], a[2*DW-1:DW]} - {s[2*DW-1], s[2*DW-1:DW]}));
        di = $signed(fit({a[DW-1], a[DW-1:0]} - {s[DW-1], s[DW-1:0]}));
        wr = $signed(tw[2*TW-1:TW]);
        // one extra bit so conjugating the most negative twiddle cannot wrap
        wi = $signed({tw[TW-1], tw[TW-1:0]});
        if (inv_q)
            wi = -wi;
        pr = PW'(dr) * PW'(wr) - PW'(di) * PW'(wi) + CM_RND;
        pi = PW'(dr) * PW'(wi) + PW'(di) * PW'(wr) + CM_RND;
        cm = {sat_cm(pr), sat_cm(pi)};
    end

    always_ff @(posedge clk) begin
        if (accept)
            mem[k] <= phase ? cm : s;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sof   <= 1'b0;
            diff_vld  <= 1'b0;
            inv_q     <= 1'b0;
        end else if (accept) begin
            cnt <= cnt + 1'b1;
            if (cnt == '0)
                inv_q <= inverse;
            if (!phase) begin
                out_data  <= a;
                out_valid <= diff_vld;
                out_sof   <= 1'b0;
            end else begin
                out_data  <= {sum_re, sum_im};
                out_valid <= 1'b1;
                out_sof   <= (k == '0);
                if (k == LOG2SPAN'(SPAN - 1))
                    diff_vld <= 1'b1;
            end
        end else begin
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fft_sdf_stage.sv
// tb/tb_fft_sdf_stage.sv - directed bench for fft_sdf_stage (SPAN=4, SCALE=1 and SCALE=0 instances)
module tb_fft_sdf_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        flush = 1'b0;
    logic        inverse = 1'b0;
    logic [31:0] tw = '0;

    logic [1:0]  tw_idx0, tw_idx1;
    logic        out_valid0, out_valid1, out_sof0, out_sof1;
    logic [31:0] out_data0, out_data1;

    logic [32:0] q0[$];
    logic [32:0] q1[$];

    int pass_cnt = 0;
    int total = 0;

    always #5 clk = ~clk;

    fft_sdf_stage #(.DW(16), .TW(16), .SPAN(4), .SCALE(1)) u0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .flush(flush),
        .inverse(inverse), .tw_idx(tw_idx0), .tw(tw), .out_valid(out_valid0),
        .out_data(out_data0), .out_sof(out_sof0)
    );

    fft_sdf_stage #(.DW(16), .TW(16), .SPAN(4), .SCALE(0)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .flush(flush),
        .inverse(inverse), .tw_idx(tw_idx1), .tw(tw), .out_valid(out_valid1),
        .out_data(out_data1), .out_sof(out_sof1)
    );

    always @(negedge clk) begin
        if (out_valid0) q0.push_back({out_sof0, out_data0});
        if (out_valid1) q1.push_back({out_sof1, out_data1});
    end

    function automatic logic [31:0] pk(input int re, input int im);
        return {re[15:0], im[15:0]};
    endfunction

    task automatic drive(input logic v, input logic f, input logic [31:0] d);
        in_valid = v;
        flush    = f;
        in_data  = d;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q0.delete();
        q1.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b1;
        in_data = pk(5, 5);
        @(posedge clk);
        @(posedge clk);
        #1;
        total++; if (out_valid0 !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", out_valid0); else pass_cnt++;
        total++; if (out_data0 !== 32'h0) $display("FAIL reset_out_data got %h exp 0", out_data0); else pass_cnt++;
        total++; if (out_sof0 !== 1'b0) $display("FAIL reset_out_sof got %b exp 0", out_sof0); else pass_cnt++;
        total++; if (tw_idx0 !== 2'd0) $display("FAIL reset_tw_idx got %0d exp 0", tw_idx0); else pass_cnt++;
        total++; if (out_valid1 !== 1'b0) $display("FAIL reset_out_valid_sat got %b exp 0", out_valid1); else pass_cnt++;
        rst = 1'b0;
        in_valid = 1'b0;
        q0.delete();
        q1.delete();
    endtask

    task automatic test_basic();
        int er[8];
        logic [1:0] ek;
        logic [32:0] got, exp_v;
        er = '{3, 4, 5, 6, -2, -2, -2, -2};
        do_reset();
        tw = pk(16384, 0);
        inverse = 1'b0;
        for (int i = 0; i < 8; i++) begin
            ek = i[1:0];
            total++; if (tw_idx0 !== ek) $display("FAIL basic_tw_idx[%0d] got %0d exp %0d", i, tw_idx0, ek); else pass_cnt++;
            drive(1'b1, 1'b0, pk(i + 1, 0));
        end
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 32'h0);
        drive(1'b0, 1'b0, 32'h0);
        total++; if (q0.size() != 8) $display("FAIL basic_count got %0d exp 8", q0.size()); else pass_cnt++;
        for (int i = 0; i < 8; i++) begin
            got = (i < q0.size()) ? q0[i] : 'x;
            exp_v = {(i == 0), pk(er[i], 0)};
            total++; if (got !== exp_v) $display("FAIL basic_out[%0d] got %h exp %h", i, got, exp_v); else pass_cnt++;
        end
    endtask

    task automatic test_twiddle();
        logic [32:0] got, exp_v;
        for (int r = 0; r < 2; r++) begin
            do_reset();
            tw = pk(0, -16384);
            for (int i = 0; i < 8; i++) begin
                // inverse only held for the frame's first sample; later changes must be ignored
                inverse = (r == 1) && (i == 0);
                drive(1'b1, 1'b0, pk(i + 1, 0));
            end
            inverse = 1'b0;
            for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 32'h0);
            drive(1'b0, 1'b0, 32'h0);
            total++; if (q0.size() != 8) $display("FAIL twiddle_count[%0d] got %0d exp 8", r, q0.size()); else pass_cnt++;
            for (int i = 4; i < 8; i++) begin
                got = (i < q0.size()) ? q0[i] : 'x;
                exp_v = {1'b0, pk(0, (r == 1) ? -2 : 2)};
                total++; if (got !== exp_v) $display("FAIL twiddle_inv%0d[%0d] got %h exp %h", r, i, got, exp_v); else pass_cnt++;
            end
        end
    endtask

    task automatic test_saturation();
        int xin[8];
        int er[8];
        logic [32:0] got, exp_v;
        xin = '{32767, 32767, -32768, -32768, 32767, -32768, 32767, -32768};
        er  = '{32767, -1, -1, -32768, 0, 32767, -32768, 0};
        do_reset();
        tw = pk(16384, 0);
        for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, pk(xin[i], 0));
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 32'h0);
        drive(1'b0, 1'b0, 32'h0);
        total++; if (q1.size() != 8) $display("FAIL sat_count got %0d exp 8", q1.size()); else pass_cnt++;
        for (int i = 0; i < 8; i++) begin
            got = (i < q1.size()) ? q1[i] : 'x;
            exp_v = {(i == 0), pk(er[i], 0)};
            total++; if (got !== exp_v) $display("FAIL sat_out[%0d] got %h exp %h", i, got, exp_v); else pass_cnt++;
        end
    endtask

    task automatic test_gaps();
        int xr[24];
        int xi[24];
        logic [32:0] exp_q[$];
        logic [32:0] got;
        int n_idle, ar, br, ai, bi;
        for (int i = 0; i < 24; i++) begin
            xr[i] = int'($urandom_range(0, 2000)) - 1000;
            xi[i] = int'($urandom_range(0, 2000)) - 1000;
        end
        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < 4; k++) begin
                ar = xr[f*8+k]; br = xr[f*8+k+4]; ai = xi[f*8+k]; bi = xi[f*8+k+4];
                exp_q.push_back({(k == 0), pk((ar + br) >>> 1, (ai + bi) >>> 1)});
            end
            for (int k = 0; k < 4; k++) begin
                ar = xr[f*8+k]; br = xr[f*8+k+4]; ai = xi[f*8+k]; bi = xi[f*8+k+4];
                exp_q.push_back({1'b0, pk((ar - br) >>> 1, (ai - bi) >>> 1)});
            end
        end
        do_reset();
        tw = pk(16384, 0);
        for (int j = 0; j < 28; j++) begin
            n_idle = (j == 5) ? 2 : (($urandom_range(0, 99) < 30) ? 1 : 0);
            for (int g = 0; g < n_idle; g++) begin
                drive(1'b0, 1'b0, 32'h0);
                total++; if (out_valid0 !== 1'b0) $display("FAIL gaps_idle_valid[%0d] got %b exp 0", j, out_valid0); else pass_cnt++;
            end
            if (j < 24) drive(1'b1, 1'b0, pk(xr[j], xi[j]));
            else drive(1'b0, 1'b1, 32'h0);
        end
        drive(1'b0, 1'b0, 32'h0);
        total++; if (q0.size() != 24) $display("FAIL gaps_count got %0d exp 24", q0.size()); else pass_cnt++;
        for (int i = 0; i < 24; i++) begin
            got = (i < q0.size()) ? q0[i] : 'x;
            total++; if (got !== exp_q[i]) $display("FAIL gaps_out[%0d] got %h exp %h", i, got, exp_q[i]); else pass_cnt++;
        end
    endtask

    task automatic test_mid_reset();
        int er[8];
        logic [32:0] got, exp_v;
        er = '{6, 8, 10, 12, -4, -4, -4, -4};
        do_reset();
        tw = pk(16384, 0);
        for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, pk(i + 1, 0));
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, pk(10, 0));
        total++; if (out_valid0 !== 1'b1) $display("FAIL midrst_pre_valid got %b exp 1", out_valid0); else pass_cnt++;
        rst = 1'b1;
        in_valid = 1'b1;
        in_data = pk(10, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = 1'b0;
        total++; if (out_valid0 !== 1'b0) $display("FAIL midrst_valid got %b exp 0", out_valid0); else pass_cnt++;
        total++; if (out_data0 !== 32'h0) $display("FAIL midrst_data got %h exp 0", out_data0); else pass_cnt++;
        total++; if (tw_idx0 !== 2'd0) $display("FAIL midrst_tw_idx got %0d exp 0", tw_idx0); else pass_cnt++;
        q0.delete();
        q1.delete();
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, pk(2 * i + 2, 0));
        total++; if (q0.size() != 0) $display("FAIL midrst_no_stale got %0d exp 0", q0.size()); else pass_cnt++;
        for (int i = 5; i < 8; i++) drive(1'b1, 1'b0, pk(2 * i + 2, 0));
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 32'h0);
        drive(1'b0, 1'b0, 32'h0);
        total++; if (q0.size() != 8) $display("FAIL midrst_count got %0d exp 8", q0.size()); else pass_cnt++;
        for (int i = 0; i < 8; i++) begin
            got = (i < q0.size()) ? q0[i] : 'x;
            exp_v = {(i == 0), pk(er[i], 0)};
            total++; if (got !== exp_v) $display("FAIL midrst_out[%0d] got %h exp %h", i, got, exp_v); else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_twiddle();
        test_saturation();
        test_gaps();
        test_mid_reset();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
